// File: rtl/countdown_ctrl_pkg.sv
// Shared encodings, digit limits and helpers for the countdown-timer control block.
// Digit index doubles as cursor index: 0 = sec_1 .. 5 = hr_10.
package countdown_ctrl_pkg;

    localparam logic [1:0] ST_SET   = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [2:0] CUR_SEC1  = 3'd0;
    localparam logic [2:0] CUR_SEC10 = 3'd1;
    localparam logic [2:0] CUR_MIN1  = 3'd2;
    localparam logic [2:0] CUR_MIN10 = 3'd3;
    localparam logic [2:0] CUR_HR1   = 3'd4;
    localparam logic [2:0] CUR_HR10  = 3'd5;

    localparam logic [3:0] LIM_UNITS = 4'd9;
    localparam logic [3:0] LIM_TENS  = 4'd5;

    localparam int NUM_DIGITS = 6;
    localparam int NUM_BTNS   = 6;

    typedef logic [3:0] bcd_t;
    typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

    // Member order fixes the bit order of the debounced pulse vector (clr is MSB).
    typedef struct packed {
        logic clr;
        logic start;
        logic left;
        logic right;
        logic up;
        logic down;
    } btn_t;

    function automatic bcd_t digit_limit(input logic [2:0] idx);
        return (idx == CUR_SEC10 || idx == CUR_MIN10) ? LIM_TENS : LIM_UNITS;
    endfunction

    function automatic bcd_t clamp_digit(input bcd_t value, input logic [2:0] idx);
        return (value > digit_limit(idx)) ? digit_limit(idx) : value;
    endfunction

endpackage

// File: rtl/countdown_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-level debounce and a one-cycle pulse
// on every accepted 0->1 transition. Holding the button produces no repeat.
module btn_debounce
    import countdown_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic pulse
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [CW-1:0] cnt;

    // cnt tracks how long the synchronised input has disagreed with the accepted level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            sync_a <= btn_in;
            sync_b <= sync_a;
            pulse  <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_b;
                pulse <= sync_b;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown-timer page: button conditioning, SET/RUN/PAUSE/DONE control FSM,
// shared tick/blink counter and the BCD HH:MM:SS edit/decrement datapath.
module countdown_ctrl
    import countdown_ctrl_pkg::*;
#(
    parameter int TICK_DIV     = 50_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       start,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] hr_10,
    input  logic [3:0] hr_1,
    input  logic [3:0] min_10,
    input  logic [3:0] min_1,
    input  logic [3:0] sec_10,
    input  logic [3:0] sec_1,
    output logic [3:0] hr_2_10,
    output logic [3:0] hr_2_1,
    output logic [3:0] min_2_10,
    output logic [3:0] min_2_1,
    output logic [3:0] sec_2_10,
    output logic [3:0] sec_2_1,
    output logic [2:0] cursor,
    output logic       running,
    output logic       done,
    output logic       blink,
    output logic [1:0] state
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] BLINK_LAST = TW'(TICK_DIV / 2 - 1);

    logic [NUM_BTNS-1:0] raw_vec;
    logic [NUM_BTNS-1:0] pulse_vec;
    btn_t                pulse;

    digits_t       dig;
    digits_t       dig_nxt;
    digits_t       dec;
    digits_t       preset;
    logic [TW-1:0] tick;
    logic [TW-1:0] tick_nxt;
    logic [1:0]    state_q;
    logic [1:0]    state_nxt;
    logic [2:0]    cursor_nxt;
    logic          blink_nxt;
    logic          borrow;

    assign raw_vec = {clr, start, left, right, up, down};
    assign pulse   = btn_t'(pulse_vec);
    assign preset  = {hr_10, hr_1, min_10, min_1, sec_10, sec_1};

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_btn (
            .clk   (clk),
            .reset (reset),
            .btn_in(raw_vec[g]),
            .pulse (pulse_vec[g])
        );
    end

    // One-second decrement: a zero digit wraps to its limit and passes the borrow upward.
    always_comb begin
        dec    = dig;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (dig[i] == 4'd0) begin
                    dec[i] = digit_limit(3'(i));
                end else begin
                    dec[i] = dig[i] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    // Pulses are tested in priority order, so only the highest-priority one acts.
    always_comb begin
        state_nxt  = state_q;
        dig_nxt    = dig;
        cursor_nxt = cursor;
        tick_nxt   = tick;
        blink_nxt  = blink;
        case (state_q)
            ST_SET: begin
                if (pulse.clr) begin
                    dig_nxt = '0;
                end else if (pulse.start) begin
                    if (dig != '0) begin
                        state_nxt = ST_RUN;
                        tick_nxt  = '0;
                    end
                end else if (pulse.left) begin
                    cursor_nxt = (cursor == CUR_SEC1) ? CUR_HR10 : cursor - 3'd1;
                end else if (pulse.right) begin
                    cursor_nxt = (cursor == CUR_HR10) ? CUR_SEC1 : cursor + 3'd1;
                end else if (pulse.up) begin
                    dig_nxt[cursor] = (dig[cursor] >= digit_limit(cursor)) ? 4'd0
                                                                           : dig[cursor] + 4'd1;
                end else if (pulse.down) begin
                    dig_nxt[cursor] = (dig[cursor] == 4'd0) ? digit_limit(cursor)
                                                            : dig[cursor] - 4'd1;
                end else if (load) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        dig_nxt[i] = clamp_digit(preset[i], 3'(i));
                    end
                end
            end
            ST_RUN: begin
                if (pulse.clr) begin
                    state_nxt = ST_SET;
                    dig_nxt   = '0;
                    tick_nxt  = '0;
                end else if (pulse.start) begin
                    state_nxt = ST_PAUSE;
                end else if (tick == TICK_LAST) begin
                    tick_nxt = '0;
                    dig_nxt  = dec;
                    if (dec == '0) begin
                        state_nxt = ST_DONE;
                        blink_nxt = 1'b0;
                    end
                end else begin
                    tick_nxt = tick + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (pulse.clr) begin
                    state_nxt = ST_SET;
                    dig_nxt   = '0;
                    tick_nxt  = '0;
                end else if (pulse.start) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                // DONE reuses the tick counter as the half-period blink divider.
                if (pulse.clr || pulse.start) begin
                    state_nxt  = ST_SET;
                    cursor_nxt = CUR_SEC1;
                    blink_nxt  = 1'b0;
                    tick_nxt   = '0;
                end else if (tick == BLINK_LAST) begin
                    tick_nxt  = '0;
                    blink_nxt = ~blink;
                end else begin
                    tick_nxt = tick + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SET;
            dig     <= '0;
            cursor  <= CUR_SEC1;
            tick    <= '0;
            blink   <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            dig     <= dig_nxt;
            cursor  <= cursor_nxt;
            tick    <= tick_nxt;
            blink   <= blink_nxt;
            running <= (state_nxt == ST_RUN);
            done    <= (state_nxt == ST_DONE);
        end
    end

    assign state    = state_q;
    assign hr_2_10  = dig[CUR_HR10];
    assign hr_2_1   = dig[CUR_HR1];
    assign min_2_10 = dig[CUR_MIN10];
    assign min_2_1  = dig[CUR_MIN1];
    assign sec_2_10 = dig[CUR_SEC10];
    assign sec_2_1  = dig[CUR_SEC1];

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl: expected values queue up as stimulus is applied
// and are popped when the corresponding DUT output is sampled on the falling edge.
module tb_countdown_ctrl;

    localparam int TICK_DIV     = 10;
    localparam int DEBOUNCE_CYC = 4;

    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;
    localparam int B_START = 4;
    localparam int B_CLR   = 5;

    localparam logic [1:0] S_SET   = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       load  = 1'b0;
    logic [5:0] btn   = '0;
    logic [23:0] preset = '0;

    logic [3:0] hr_2_10, hr_2_1, min_2_10, min_2_1, sec_2_10, sec_2_1;
    logic [2:0] cursor;
    logic       running, done, blink;
    logic [1:0] state;
    logic [23:0] dig_obs;

    logic [23:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int lat    = 6;
    int n      = 0;

    assign dig_obs = {hr_2_10, hr_2_1, min_2_10, min_2_1, sec_2_10, sec_2_1};

    always #5 clk = ~clk;

    countdown_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .up      (btn[B_UP]),
        .down    (btn[B_DOWN]),
        .left    (btn[B_LEFT]),
        .right   (btn[B_RIGHT]),
        .start   (btn[B_START]),
        .clr     (btn[B_CLR]),
        .load    (load),
        .hr_10   (preset[23:20]),
        .hr_1    (preset[19:16]),
        .min_10  (preset[15:12]),
        .min_1   (preset[11:8]),
        .sec_10  (preset[7:4]),
        .sec_1   (preset[3:0]),
        .hr_2_10 (hr_2_10),
        .hr_2_1  (hr_2_1),
        .min_2_10(min_2_10),
        .min_2_1 (min_2_1),
        .sec_2_10(sec_2_10),
        .sec_2_1 (sec_2_1),
        .cursor  (cursor),
        .running (running),
        .done    (done),
        .blink   (blink),
        .state   (state)
    );

    task automatic push(input logic [23:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [23:0] obs);
        logic [23:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s observed %0h expected <empty queue>", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
            end
        end
    endtask

    task automatic press(input int idx);
        btn[idx] = 1'b1;
        repeat (8) @(negedge clk);
        btn[idx] = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic load_preset(input logic [23:0] v);
        preset = v;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        @(negedge clk);
    endtask

    // Bounded wait; the caller's following state check reports a timeout.
    task automatic wait_state(input logic [1:0] target, output int cyc);
        cyc = 0;
        while (state !== target && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        push(24'h000000); check("rst_digits", dig_obs);
        push(24'd0);      check("rst_cursor", {21'd0, cursor});
        push(24'd0);      check("rst_running", {23'd0, running});
        push(24'd0);      check("rst_done", {23'd0, done});
        push(24'd0);      check("rst_blink", {23'd0, blink});
        push(24'd0);      check("rst_state", {22'd0, state});

        // Edit
        push(24'd3);
        press(B_UP); press(B_UP); press(B_UP);
        check("edit_up3", {20'd0, sec_2_1});
        push(24'd1);
        press(B_RIGHT);
        check("edit_right", {21'd0, cursor});
        push(24'd5);
        press(B_DOWN);
        check("edit_sec10_wrap", {20'd0, sec_2_10});
        push(24'd5);
        press(B_LEFT); press(B_LEFT);
        check("edit_left2", {21'd0, cursor});
        push(24'd9);
        press(B_DOWN);
        check("edit_hr10_down", {20'd0, hr_2_10});
        push(24'd0);
        press(B_UP);
        check("edit_hr10_up_wrap", {20'd0, hr_2_10});
        push(24'h000053);
        check("edit_value", dig_obs);

        // Load clamp and borrow
        push(24'h995355);
        load_preset(24'h9FE375);
        check("load_clamp", dig_obs);
        push(24'h010000);
        load_preset(24'h010000);
        check("load_value", dig_obs);
        push({22'd0, S_RUN});
        btn[B_START] = 1'b1;
        wait_state(S_RUN, lat);
        btn[B_START] = 1'b0;
        check("borrow_start", {22'd0, state});
        push(24'd1);
        check("borrow_running", {23'd0, running});
        if (lat > 8) lat = 8;
        push(24'h010000);
        repeat (9) @(negedge clk);
        check("borrow_before", dig_obs);
        push(24'h005959);
        @(negedge clk);
        check("borrow_first", dig_obs);
        push(24'h005958);
        repeat (10) @(negedge clk);
        check("borrow_second", dig_obs);
        push({22'd0, S_SET});
        btn[B_CLR] = 1'b1;
        wait_state(S_SET, n);
        btn[B_CLR] = 1'b0;
        repeat (8) @(negedge clk);
        check("run_clr_state", {22'd0, state});
        push(24'h000000);
        check("run_clr_digits", dig_obs);

        // Completion
        load_preset(24'h000002);
        push({22'd0, S_RUN});
        btn[B_START] = 1'b1;
        wait_state(S_RUN, n);
        btn[B_START] = 1'b0;
        check("done_start", {22'd0, state});
        push(24'd0);
        repeat (19) @(negedge clk);
        check("done_early", {23'd0, done});
        @(negedge clk);
        push(24'd1);      check("done_flag", {23'd0, done});
        push(24'd0);      check("done_running", {23'd0, running});
        push(24'h000000); check("done_digits", dig_obs);
        push({22'd0, S_DONE}); check("done_state", {22'd0, state});
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 4 || k == 5 || k == 9 || k == 10) begin
                push({23'd0, ((k / 5) % 2) == 1});
                check("done_blink", {23'd0, blink});
            end
        end
        btn[B_START] = 1'b1;
        wait_state(S_SET, n);
        btn[B_START] = 1'b0;
        repeat (8) @(negedge clk);
        push({22'd0, S_SET}); check("ack_state", {22'd0, state});
        push(24'd0);          check("ack_done", {23'd0, done});
        push(24'd0);          check("ack_blink", {23'd0, blink});
        push(24'd0);          check("ack_cursor", {21'd0, cursor});

        // Start at zero is ignored
        push({22'd0, S_SET});
        press(B_START);
        check("zero_start", {22'd0, state});

        // Pause at tick count 7, resume three cycles before the next decrement
        load_preset(24'h000030);
        push({22'd0, S_RUN});
        btn[B_START] = 1'b1;
        wait_state(S_RUN, n);
        btn[B_START] = 1'b0;
        check("pause_run", {22'd0, state});
        push(24'h000029);
        repeat (10) @(negedge clk);
        check("pause_first_dec", dig_obs);
        repeat (8 - lat) @(negedge clk);
        push({22'd0, S_PAUSE});
        btn[B_START] = 1'b1;
        repeat (lat) @(negedge clk);
        btn[B_START] = 1'b0;
        check("pause_enter", {22'd0, state});
        push(24'h000029);
        repeat (50) @(negedge clk);
        check("pause_hold", dig_obs);
        push({22'd0, S_RUN});
        btn[B_START] = 1'b1;
        repeat (lat) @(negedge clk);
        btn[B_START] = 1'b0;
        check("pause_resume", {22'd0, state});
        push(24'h000029);
        repeat (2) @(negedge clk);
        check("resume_before", dig_obs);
        push(24'h000028);
        @(negedge clk);
        check("resume_dec", dig_obs);

        // clr and start accepted together in RUN
        push({22'd0, S_SET});
        btn[B_CLR]   = 1'b1;
        btn[B_START] = 1'b1;
        wait_state(S_SET, n);
        btn[B_CLR]   = 1'b0;
        btn[B_START] = 1'b0;
        repeat (8) @(negedge clk);
        check("prio_state", {22'd0, state});
        push(24'h000000);
        check("prio_digits", dig_obs);

        // A 3-cycle start press is rejected by the debouncer
        load_preset(24'h000005);
        push({22'd0, S_SET});
        btn[B_START] = 1'b1;
        repeat (3) @(negedge clk);
        btn[B_START] = 1'b0;
        repeat (12) @(negedge clk);
        check("short_press", {22'd0, state});

        // Asynchronous reset mid-RUN
        push(24'd1);
        press(B_RIGHT);
        check("pre_rst_cursor", {21'd0, cursor});
        push({22'd0, S_RUN});
        btn[B_START] = 1'b1;
        wait_state(S_RUN, n);
        btn[B_START] = 1'b0;
        check("pre_rst_run", {22'd0, state});
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        push(24'h000000); check("arst_digits", dig_obs);
        push(24'd0);      check("arst_running", {23'd0, running});
        push(24'd0);      check("arst_cursor", {21'd0, cursor});
        push({22'd0, S_SET}); check("arst_state", {22'd0, state});
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        push({22'd0, S_SET}); check("post_rst_state", {22'd0, state});
        push(24'd0);          check("post_rst_cursor", {21'd0, cursor});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
